calc_token_parser: RTL and testbench
====================================

Name: calc_token_parser

Overview:
- Consumer end of the keypad token stream: accepts 5-bit key tokens over a valid/ready handshake.
- Accumulates hex digits into operands A and B and issues an operation to the arithmetic unit over a command handshake.
- Loads the returned result back into A to support chained operations.
- Drives the value to be shown on the display.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4.
- MAXD, WIDTH/4, maximum digits per operand; further digits are dropped.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_data  input  5  key token: {0,d[3:0]} is digit d (0..15); {1,0,c[2:0]} is a control key: c=0 AC, 1 +, 2 -, 3 *, 4 /, 5 =, 6/7 invalid
- i_valid  input  1  token valid
- o_ready  output  1  parser can accept a token
- o_cmd_valid  output  1  command valid
- o_cmd_op  output  2  0 add, 1 sub, 2 mul, 3 div
- o_cmd_a  output  WIDTH  operand A
- o_cmd_b  output  WIDTH  operand B
- i_cmd_ready  input  1  arithmetic unit accepts the command
- i_res_valid  input  1  result valid (single-cycle pulse)
- i_res_data  input  WIDTH  result
- i_res_err  input  1  result error (e.g. divide by zero), qualified by i_res_valid
- o_display  output  WIDTH  value to display
- o_error  output  1  sticky error flag

Behaviour:
- Token accepted on a clk edge when i_valid && o_ready. One token per cycle, no buffering, registered updates.
- Registers: A, B, op (2b), pending_op (2b), pending flag, dcnt (digit count), err, state.
- Reset: state S_A, A=B=0, op=0, pending=0, dcnt=0, err=0. All outputs are 0 except o_ready=1.
- o_ready=1 in S_A, S_OP, S_B, S_RES; o_ready=0 in S_ISSUE, S_WAIT.
- Digit shift: X <= {X[WIDTH-5:0], d}, dcnt++. Applies only if dcnt<MAXD, otherwise the digit is consumed and dropped. Leading zeros count toward dcnt.
- AC, in any state with o_ready=1: A=B=0, op=0, pending=0, dcnt=0, err=0, next state S_A.
- When err=1, all tokens except AC are consumed and ignored.
- Invalid codes 6/7 are always consumed and ignored.
- S_A:
  - digit: shift into A.
  - + - * /: op set, dcnt=0, next state S_OP.
  - =: ignored.
- S_OP:
  - digit: B=d, dcnt=1, next state S_B.
  - operator: replaces op.
  - =: ignored.
- S_B:
  - digit: shift into B.
  - =: pending=0, next state S_ISSUE.
  - operator: pending_op=that op, pending=1, next state S_ISSUE.
- S_ISSUE:
  - o_cmd_valid=1; o_cmd_op/a/b = op/A/B, held stable until the handshake.
  - On i_cmd_ready: next state S_WAIT, o_cmd_valid drops the following cycle.
- S_WAIT:
  - On i_res_valid: A=i_res_data, err |= i_res_err, dcnt=0.
  - If pending: op=pending_op, pending=0, next state S_OP; otherwise next state S_RES.
  - i_res_valid outside S_WAIT is ignored.
- S_RES:
  - digit: A=d, dcnt=1, next state S_A (starts a new calculation).
  - operator: op set, next state S_OP (chains on the result).
  - =: ignored.
- o_display = B in S_B; A in all other states. Registered, so it updates the cycle after the triggering token or result.
- o_error = err.
- Latency: the = token accepted at edge N gives o_cmd_valid=1 from cycle N+1.
- Reset mid-command: everything is cleared immediately, and o_cmd_valid drops asynchronously.

Test Plan:
- Tokens 1,2,+,3,= with i_cmd_ready=1, result 0x15 after 2 cycles -> o_cmd_op=0, a=0x12, b=0x3. o_display sequence: 0x1, 0x12, 0x12, 0x3, then 0x15. o_ready low during issue/wait.
- Five digits 1,2,3,4,5 with WIDTH=16 -> A=0x1234, fifth digit dropped, o_ready stays 1.
- 8,*,2,+,1,=, results 0x10 then 0x11 -> first cmd (2, 8, 2); then op=add, A=0x10; second cmd (0, 0x10, 1); o_display=0x11.
- Hold i_cmd_ready=0 for 5 cycles in S_ISSUE with i_valid=1 -> o_cmd_* stable, no tokens accepted. Then ready=1 -> single handshake.
- 5,/,0,=, result i_res_err=1 -> o_error=1; following digits and ops ignored; AC -> o_error=0, o_display=0, state S_A.
- After result 0x15: digit 7 -> o_display=0x7 (new A); alternatively - then 2 -> cmd (1, 0x15, 0x2).

Source files
------------

// File: rtl/calc_token_parser.sv
// Calculator token parser: gathers hex digit and operator keys into operands A/B,
// issues operations to the arithmetic unit and loads results back into A for chaining.
module calc_token_parser #(
    parameter int WIDTH = 16,
    parameter int MAXD  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_cmd_valid,
    output logic [1:0]       o_cmd_op,
    output logic [WIDTH-1:0] o_cmd_a,
    output logic [WIDTH-1:0] o_cmd_b,
    input  logic             i_cmd_ready,
    input  logic             i_res_valid,
    input  logic [WIDTH-1:0] i_res_data,
    input  logic             i_res_err,
    output logic [WIDTH-1:0] o_display,
    output logic             o_error
);

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_OP    = 3'd1,
        S_B     = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_RES   = 3'd5
    } state_e;

    localparam int               CNT_W  = $clog2(MAXD + 1);
    localparam logic [CNT_W-1:0] MAXD_C = CNT_W'(MAXD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       pop_q, pop_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    logic             tok_acc;
    logic             tok_digit;
    logic             tok_ac;
    logic             tok_op;
    logic             tok_eq;
    logic [3:0]       tok_d;
    logic [1:0]       tok_opc;

    function automatic logic [WIDTH-1:0] shift_digit(input logic [WIDTH-1:0] x,
                                                     input logic [3:0]       d);
        return {x[WIDTH-5:0], d};
    endfunction

    function automatic logic [WIDTH-1:0] digit_word(input logic [3:0] d);
        return {{(WIDTH-4){1'b0}}, d};
    endfunction

    assign o_ready   = (state_q != S_ISSUE) && (state_q != S_WAIT);
    assign tok_acc   = i_valid && o_ready;
    assign tok_digit = ~i_data[4];
    assign tok_d     = i_data[3:0];

    // Control keys are {1,0,c}; every other pattern with bit 4 set is treated as invalid
    assign tok_ac  = (i_data == 5'h10);
    assign tok_op  = i_data[4] && !i_data[3] && (i_data[2:0] >= 3'd1) && (i_data[2:0] <= 3'd4);
    assign tok_eq  = (i_data == 5'h15);
    assign tok_opc = i_data[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        pop_d   = pop_q;
        pend_d  = pend_q;
        err_d   = err_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            S_ISSUE: begin
                if (i_cmd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_res_valid) begin
                    a_d    = i_res_data;
                    err_d  = err_q | i_res_err;
                    dcnt_d = '0;
                    if (pend_q) begin
                        op_d    = pop_q;
                        pend_d  = 1'b0;
                        state_d = S_OP;
                    end else begin
                        state_d = S_RES;
                    end
                end
            end
            default: begin
                if (tok_acc && tok_ac) begin
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = 2'd0;
                    pend_d  = 1'b0;
                    dcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_A;
                end else if (tok_acc && !err_q) begin
                    // Operand entry states; '=' outside S_B and invalid codes fall through untouched
                    case (state_q)
                        S_A: begin
                            if (tok_digit) begin
                                if (dcnt_q < MAXD_C) begin
                                    a_d    = shift_digit(a_q, tok_d);
                                    dcnt_d = dcnt_q + ONE_C;
                                end
                            end else if (tok_op) begin
                                op_d    = tok_opc;
                                dcnt_d  = '0;
                                state_d = S_OP;
                            end
                        end
                        S_OP: begin
                            if (tok_digit) begin
                                b_d     = digit_word(tok_d);
                                dcnt_d  = ONE_C;
                                state_d = S_B;
                            end else if (tok_op) begin
                                op_d = tok_opc;
                            end
                        end
                        S_B: begin
                            if (tok_digit) begin
                                if (dcnt_q < MAXD_C) begin
                                    b_d    = shift_digit(b_q, tok_d);
                                    dcnt_d = dcnt_q + ONE_C;
                                end
                            end else if (tok_eq) begin
                                pend_d  = 1'b0;
                                state_d = S_ISSUE;
                            end else if (tok_op) begin
                                pop_d   = tok_opc;
                                pend_d  = 1'b1;
                                state_d = S_ISSUE;
                            end
                        end
                        S_RES: begin
                            if (tok_digit) begin
                                a_d     = digit_word(tok_d);
                                dcnt_d  = ONE_C;
                                state_d = S_A;
                            end else if (tok_op) begin
                                op_d    = tok_opc;
                                state_d = S_OP;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
        endcase

        // Display tracks the operand being edited: B while entering it, A otherwise
        disp_d = (state_d == S_B) ? b_d : a_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
            op_q    <= 2'd0;
            pop_q   <= 2'd0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            op_q    <= op_d;
            pop_q   <= pop_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign o_cmd_valid = (state_q == S_ISSUE);
    assign o_cmd_op    = op_q;
    assign o_cmd_a     = a_q;
    assign o_cmd_b     = b_q;
    assign o_display   = disp_q;
    assign o_error     = err_q;

endmodule

// File: tb/tb_calc_token_parser.sv
// Bench for calc_token_parser: directed scenarios plus random token streams,
// checked every cycle against a token-level calculator model and an ALU stand-in.
module tb_calc_token_parser;

    localparam int WIDTH = 16;

    localparam logic [4:0] K_AC  = 5'h10;
    localparam logic [4:0] K_ADD = 5'h11;
    localparam logic [4:0] K_SUB = 5'h12;
    localparam logic [4:0] K_MUL = 5'h13;
    localparam logic [4:0] K_DIV = 5'h14;
    localparam logic [4:0] K_EQ  = 5'h15;

    localparam logic [2:0] PH_A     = 3'd0;
    localparam logic [2:0] PH_OP    = 3'd1;
    localparam logic [2:0] PH_B     = 3'd2;
    localparam logic [2:0] PH_ISSUE = 3'd3;
    localparam logic [2:0] PH_WAIT  = 3'd4;
    localparam logic [2:0] PH_RES   = 3'd5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       i_data = 5'd0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic             o_cmd_valid;
    logic [1:0]       o_cmd_op;
    logic [WIDTH-1:0] o_cmd_a;
    logic [WIDTH-1:0] o_cmd_b;
    logic             i_cmd_ready = 1'b0;
    logic             i_res_valid = 1'b0;
    logic [WIDTH-1:0] i_res_data = '0;
    logic             i_res_err = 1'b0;
    logic [WIDTH-1:0] o_display;
    logic             o_error;

    always #5 clk = ~clk;

    calc_token_parser #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_op    (o_cmd_op),
        .o_cmd_a     (o_cmd_a),
        .o_cmd_b     (o_cmd_b),
        .i_cmd_ready (i_cmd_ready),
        .i_res_valid (i_res_valid),
        .i_res_data  (i_res_data),
        .i_res_err   (i_res_err),
        .o_display   (o_display),
        .o_error     (o_error)
    );

    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [1:0]  pop;
        logic        pend;
        logic [3:0]  cnt;
        logic        err;
    } mstate_t;

    mstate_t m = '0;

    // Calculator behaviour at the level of whole tokens and results
    function automatic mstate_t step(input mstate_t s, input logic v, input logic [4:0] t,
                                     input logic crdy, input logic rv,
                                     input logic [15:0] rd, input logic re);
        mstate_t n;
        logic [3:0] d;
        int code;
        n = s;
        d = t[3:0];
        code = int'(t[2:0]);
        if (s.ph == PH_ISSUE) begin
            if (crdy) n.ph = PH_WAIT;
        end else if (s.ph == PH_WAIT) begin
            if (rv) begin
                n.a = rd;
                n.err = s.err | re;
                n.cnt = 4'd0;
                if (s.pend) begin
                    n.op = s.pop;
                    n.pend = 1'b0;
                    n.ph = PH_OP;
                end else begin
                    n.ph = PH_RES;
                end
            end
        end else if (v) begin
            if (t == K_AC) begin
                n = '0;
            end else if (s.err || (t[4] && (t[3] || code > 5))) begin
                n = s;
            end else if (!t[4]) begin
                case (s.ph)
                    PH_A: if (s.cnt < 4'd4) begin
                        n.a = 16'(s.a * 16 + int'(d));
                        n.cnt = s.cnt + 4'd1;
                    end
                    PH_OP: begin
                        n.b = 16'(d);
                        n.cnt = 4'd1;
                        n.ph = PH_B;
                    end
                    PH_B: if (s.cnt < 4'd4) begin
                        n.b = 16'(s.b * 16 + int'(d));
                        n.cnt = s.cnt + 4'd1;
                    end
                    PH_RES: begin
                        n.a = 16'(d);
                        n.cnt = 4'd1;
                        n.ph = PH_A;
                    end
                    default: n = s;
                endcase
            end else if (code == 5) begin
                if (s.ph == PH_B) begin
                    n.pend = 1'b0;
                    n.ph = PH_ISSUE;
                end
            end else begin
                case (s.ph)
                    PH_A: begin
                        n.op = 2'(code - 1);
                        n.cnt = 4'd0;
                        n.ph = PH_OP;
                    end
                    PH_OP: n.op = 2'(code - 1);
                    PH_B: begin
                        n.pop = 2'(code - 1);
                        n.pend = 1'b1;
                        n.ph = PH_ISSUE;
                    end
                    PH_RES: begin
                        n.op = 2'(code - 1);
                        n.ph = PH_OP;
                    end
                    default: n = s;
                endcase
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, i_valid, i_data, i_cmd_ready, i_res_valid, i_res_data, i_res_err);
    end

    int          checks = 0;
    int          errors = 0;
    int          res_cnt = 0;
    logic [15:0] res_data = '0;
    logic        res_err = 1'b0;
    int          n_hs = 0;
    int          fixed_delay = 1;
    bit          rand_delay = 1'b0;
    bit          rand_ready = 1'b0;
    bit          spurious = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("ready", 32'(o_ready), 32'(m.ph != PH_ISSUE && m.ph != PH_WAIT));
        chk("cmd_valid", 32'(o_cmd_valid), 32'(m.ph == PH_ISSUE));
        chk("display", 32'(o_display), 32'((m.ph == PH_B) ? m.b : m.a));
        chk("error", 32'(o_error), 32'(m.err));
        if (m.ph == PH_ISSUE) begin
            chk("cmd_op", 32'(o_cmd_op), 32'(m.op));
            chk("cmd_a", 32'(o_cmd_a), 32'(m.a));
            chk("cmd_b", 32'(o_cmd_b), 32'(m.b));
        end
    endtask

    task automatic alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        res_err = 1'b0;
        case (op)
            2'd0: res_data = a + b;
            2'd1: res_data = a - b;
            2'd2: res_data = a * b;
            default: begin
                if (b == 16'd0) begin
                    res_data = 16'd0;
                    res_err = 1'b1;
                end else begin
                    res_data = a / b;
                end
            end
        endcase
    endtask

    // One clock: compare at the falling edge, then drive the next inputs
    task automatic cycle();
        logic hs;
        logic [1:0] hop;
        logic [15:0] ha, hb;
        hs = o_cmd_valid && i_cmd_ready && rst_n;
        hop = o_cmd_op;
        ha = o_cmd_a;
        hb = o_cmd_b;
        @(negedge clk);
        compare_model();
        #1;
        i_res_valid = 1'b0;
        i_res_err = 1'b0;
        if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
                i_res_valid = 1'b1;
                i_res_data = res_data;
                i_res_err = res_err;
            end
        end else if (spurious && $urandom_range(0, 15) == 0) begin
            i_res_valid = 1'b1;
            i_res_data = 16'($urandom);
            i_res_err = 1'($urandom_range(0, 1));
        end
        if (hs) begin
            n_hs++;
            alu(hop, ha, hb);
            res_cnt = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
        end
        if (rand_ready) i_cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [4:0] t);
        int n;
        n = 0;
        i_data = t;
        i_valid = 1'b1;
        while (!o_ready && n < 100) begin
            cycle();
            n++;
        end
        if (!o_ready) chk("send_ready_timeout", 32'(o_ready), 32'd1);
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            cycle();
            n++;
        end
        chk("wait_ready_timeout", 32'(o_ready), 32'd1);
    endtask

    function automatic logic [4:0] rand_token();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return {1'b0, 4'($urandom)};
        if (r < 85) return K_ADD + 5'($urandom_range(0, 3));
        if (r < 93) return K_EQ;
        if (r < 96) return K_AC;
        return 5'h16 + 5'($urandom_range(0, 1));
    endfunction

    initial begin
        int hs0;
        repeat (3) cycle();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        chk("rst_cmd_op", 32'(o_cmd_op), 32'd0);
        chk("rst_cmd_a", 32'(o_cmd_a), 32'd0);
        chk("rst_cmd_b", 32'(o_cmd_b), 32'd0);
        chk("rst_display", 32'(o_display), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        rst_n = 1'b1;
        i_cmd_ready = 1'b1;
        fixed_delay = 2;
        cycle();

        // 1 2 + 3 =
        send(5'h01); chk("t1_disp_1", 32'(o_display), 32'h1);
        send(5'h02); chk("t1_disp_12", 32'(o_display), 32'h12);
        send(K_ADD); chk("t1_disp_op", 32'(o_display), 32'h12);
        send(5'h03); chk("t1_disp_3", 32'(o_display), 32'h3);
        send(K_EQ);
        chk("t1_cmd_valid", 32'(o_cmd_valid), 32'd1);
        chk("t1_ready_low", 32'(o_ready), 32'd0);
        chk("t1_cmd_op", 32'(o_cmd_op), 32'd0);
        chk("t1_cmd_a", 32'(o_cmd_a), 32'h12);
        chk("t1_cmd_b", 32'(o_cmd_b), 32'h3);
        wait_ready();
        chk("t1_result", 32'(o_display), 32'h15);

        // digit after result starts a new A
        send(5'h07); chk("t6_new_a", 32'(o_display), 32'h7);

        // five digits, fifth dropped
        fixed_delay = 1;
        send(K_AC);
        send(5'h01); send(5'h02); send(5'h03); send(5'h04); send(5'h05);
        chk("t2_maxd", 32'(o_display), 32'h1234);
        chk("t2_ready", 32'(o_ready), 32'd1);

        // 8 * 2 + 1 = chained
        send(K_AC);
        send(5'h08); send(K_MUL); send(5'h02); send(K_ADD);
        chk("t3_cmd1_op", 32'(o_cmd_op), 32'd2);
        chk("t3_cmd1_a", 32'(o_cmd_a), 32'h8);
        chk("t3_cmd1_b", 32'(o_cmd_b), 32'h2);
        wait_ready();
        chk("t3_chain_a", 32'(o_display), 32'h10);
        send(5'h01); send(K_EQ);
        chk("t3_cmd2_op", 32'(o_cmd_op), 32'd0);
        chk("t3_cmd2_a", 32'(o_cmd_a), 32'h10);
        chk("t3_cmd2_b", 32'(o_cmd_b), 32'h1);
        wait_ready();
        chk("t3_result", 32'(o_display), 32'h11);

        // command held while the unit is not ready
        send(K_AC);
        send(5'h01); send(K_ADD); send(5'h02);
        i_cmd_ready = 1'b0;
        send(K_EQ);
        hs0 = n_hs;
        i_data = 5'h09;
        i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_hold_valid", 32'(o_cmd_valid), 32'd1);
            chk("t4_hold_ready", 32'(o_ready), 32'd0);
            chk("t4_hold_a", 32'(o_cmd_a), 32'h1);
            chk("t4_hold_b", 32'(o_cmd_b), 32'h2);
        end
        i_valid = 1'b0;
        i_cmd_ready = 1'b1;
        cycle();
        wait_ready();
        chk("t4_result", 32'(o_display), 32'h3);
        chk("t4_one_handshake", 32'(n_hs - hs0), 32'd1);

        // divide by zero, sticky error, AC recovery
        send(K_AC);
        send(5'h05); send(K_DIV); send(5'h00); send(K_EQ);
        wait_ready();
        chk("t5_err", 32'(o_error), 32'd1);
        send(5'h03); send(K_ADD); send(5'h04);
        chk("t5_ignored_disp", 32'(o_display), 32'h0);
        chk("t5_ignored_ready", 32'(o_ready), 32'd1);
        chk("t5_err_sticky", 32'(o_error), 32'd1);
        send(K_AC);
        chk("t5_ac_err", 32'(o_error), 32'd0);
        chk("t5_ac_disp", 32'(o_display), 32'h0);

        // chain a subtraction on a result
        send(5'h01); send(5'h02); send(K_ADD); send(5'h03); send(K_EQ);
        wait_ready();
        send(K_SUB); send(5'h02); send(K_EQ);
        chk("t6_cmd_op", 32'(o_cmd_op), 32'd1);
        chk("t6_cmd_a", 32'(o_cmd_a), 32'h15);
        chk("t6_cmd_b", 32'(o_cmd_b), 32'h2);
        wait_ready();
        chk("t6_result", 32'(o_display), 32'h13);

        // reset in the middle of a command
        send(5'h04); send(K_ADD); send(5'h04);
        i_cmd_ready = 1'b0;
        send(K_EQ);
        chk("t7_pre_valid", 32'(o_cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_valid", 32'(o_cmd_valid), 32'd0);
        chk("t7_async_ready", 32'(o_ready), 32'd1);
        chk("t7_async_disp", 32'(o_display), 32'h0);
        res_cnt = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
        i_cmd_ready = 1'b1;
        cycle();

        // randomized traffic
        rand_delay = 1'b1;
        rand_ready = 1'b1;
        spurious = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_data = rand_token();
            cycle();
        end
        i_valid = 1'b0;
        rand_ready = 1'b0;
        spurious = 1'b0;
        i_cmd_ready = 1'b1;
        cycle();
        wait_ready();
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
